// File: rtl/gpio_in_filter_if.sv
// Pad-side and controller-side signals of the GPIO input filter.
// The filter itself connects through the slave modport.
interface gpio_in_filter_if #(
    parameter int WIDTH = 32
) ();
    logic [WIDTH-1:0] PAD_I;
    logic             BYPASS;
    logic [WIDTH-1:0] GPIO_I;
    logic [WIDTH-1:0] RISE;
    logic [WIDTH-1:0] FALL;

    modport master (
        output PAD_I,
        output BYPASS,
        input  GPIO_I,
        input  RISE,
        input  FALL
    );

    modport slave (
        input  PAD_I,
        input  BYPASS,
        output GPIO_I,
        output RISE,
        output FALL
    );
endinterface

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: per-bit synchroniser, debounce against a shared sample tick,
// and registered rise/fall event pulses. BYPASS forwards the synchronised value directly.
module gpio_in_filter #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TICK_DIV    = 1000,
    parameter int FILT_LEN    = 3
) (
    input  logic            CLK,
    input  logic            RST,
    gpio_in_filter_if.slave bus
);

    localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

    logic [WIDTH-1:0]    sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]    s;
    logic [15:0]         pc;
    logic                tick;
    logic [FILT_LEN-1:0] hist_q [WIDTH];
    logic [FILT_LEN-1:0] hist_d [WIDTH];
    logic [WIDTH-1:0]    gpio_q;
    logic [WIDTH-1:0]    gpio_d;
    logic [WIDTH-1:0]    rise_q;
    logic [WIDTH-1:0]    fall_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= bus.PAD_I;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign tick = (pc == TICK_LAST);

    // The prescaler free-runs, so every bit samples on the same tick phase.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pc <= '0;
        end else if (tick) begin
            pc <= '0;
        end else begin
            pc <= pc + 16'd1;
        end
    end

    // In bypass the history is preloaded with s so leaving bypass cannot cause a transition.
    always_comb begin
        gpio_d = gpio_q;
        for (int i = 0; i < WIDTH; i++) begin
            logic [FILT_LEN-1:0] shifted;
            shifted   = {hist_q[i][FILT_LEN-2:0], s[i]};
            hist_d[i] = hist_q[i];
            if (bus.BYPASS) begin
                gpio_d[i] = s[i];
                hist_d[i] = {FILT_LEN{s[i]}};
            end else if (tick) begin
                hist_d[i] = shifted;
                if (&shifted) begin
                    gpio_d[i] = 1'b1;
                end else if (~|shifted) begin
                    gpio_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < WIDTH; i++) begin
                hist_q[i] <= '0;
            end
            gpio_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                hist_q[i] <= hist_d[i];
            end
            gpio_q <= gpio_d;
            rise_q <= gpio_d & ~gpio_q;
            fall_q <= ~gpio_d & gpio_q;
        end
    end

    assign bus.GPIO_I = gpio_q;
    assign bus.RISE   = rise_q;
    assign bus.FALL   = fall_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Scoreboard bench for gpio_in_filter: stimulus queues the edge events it expects,
// and a monitor pops one event for every cycle the DUT shows a RISE/FALL pulse.
module tb_gpio_in_filter;

    typedef struct {
        logic [31:0] rise;
        logic [31:0] fall;
        logic [31:0] gpio;
        int          lo;
        int          hi;
    } ev_t;

    logic CLK;
    logic RST;
    int   cyc;
    int   errors;
    int   checks;
    ev_t  sb [$];

    gpio_in_filter_if #(.WIDTH(32)) bus ();

    gpio_in_filter #(
        .WIDTH       (32),
        .SYNC_STAGES (2),
        .TICK_DIV    (4),
        .FILT_LEN    (3)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial cyc = 0;
    always @(posedge CLK) cyc = cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        checks = checks + 1;
        if (act < lo || act > hi) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: event at cycle %0d expected within %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pad, input logic byp, input logic rst);
        bus.PAD_I  = pad;
        bus.BYPASS = byp;
        RST        = rst;
    endtask

    task automatic expectEvent(input logic [31:0] r, input logic [31:0] f, input logic [31:0] g,
                               input int lo, input int hi);
        ev_t e;
        e.rise = r;
        e.fall = f;
        e.gpio = g;
        e.lo   = lo;
        e.hi   = hi;
        sb.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Monitor: any pulse must match the oldest queued event, otherwise it is unexpected.
    always @(negedge CLK) begin
        ev_t e;
        if ((bus.RISE | bus.FALL) !== 32'h0) begin
            if (sb.size() == 0) begin
                checks = checks + 1;
                errors = errors + 1;
                $display("[TB] FAIL unexpected_pulse: rise=%h fall=%h at cycle %0d, none expected",
                         bus.RISE, bus.FALL, cyc);
            end else begin
                e = sb.pop_front();
                checkOutput("event_rise", bus.RISE, e.rise);
                checkOutput("event_fall", bus.FALL, e.fall);
                checkOutput("event_gpio", bus.GPIO_I, e.gpio);
                checkRange("event_time", cyc, e.lo, e.hi);
            end
        end
    end

    initial begin
        int c;
        errors = 0;
        checks = 0;

        // Pads high through a 3-cycle reset; outputs stay clear until the filter fills.
        applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b1);
        expectEvent(32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 3 + 11, 3 + 14);
        repeat (3) begin
            @(negedge CLK);
            checkOutput("reset_gpio", bus.GPIO_I, 32'h0);
            checkOutput("reset_rise", bus.RISE, 32'h0);
            checkOutput("reset_fall", bus.FALL, 32'h0);
        end
        applyStimulus(32'hFFFF_FFFF, 1'b0, 1'b0);
        @(negedge CLK);
        checkOutput("post_reset_gpio", bus.GPIO_I, 32'h0);
        checkOutput("post_reset_rise", bus.RISE, 32'h0);
        checkOutput("post_reset_fall", bus.FALL, 32'h0);
        waitCycles(16);
        checkOutput("reset_sb_empty", 32'(sb.size()), 32'h0);
        checkOutput("reset_gpio_final", bus.GPIO_I, 32'hFFFF_FFFF);

        c = cyc;
        applyStimulus(32'h0, 1'b0, 1'b0);
        expectEvent(32'h0, 32'hFFFF_FFFF, 32'h0, c + 11, c + 14);
        waitCycles(20);
        checkOutput("clear_sb_empty", 32'(sb.size()), 32'h0);

        // Single-bit step up and back down.
        c = cyc;
        applyStimulus(32'h1, 1'b0, 1'b0);
        expectEvent(32'h1, 32'h0, 32'h1, c + 11, c + 14);
        waitCycles(20);
        checkOutput("step_sb_empty", 32'(sb.size()), 32'h0);
        checkOutput("step_gpio", bus.GPIO_I, 32'h1);
        c = cyc;
        applyStimulus(32'h0, 1'b0, 1'b0);
        expectEvent(32'h0, 32'h1, 32'h0, c + 11, c + 14);
        waitCycles(20);
        checkOutput("step_down_sb_empty", 32'(sb.size()), 32'h0);

        // 8-cycle glitches are rejected at every prescaler phase; 12-cycle pulses pass.
        for (int ph = 0; ph < 4; ph++) begin
            while ((cyc % 4) != ph) @(negedge CLK);
            applyStimulus(32'h20, 1'b0, 1'b0);
            waitCycles(8);
            applyStimulus(32'h0, 1'b0, 1'b0);
            waitCycles(20);
            checkOutput("glitch8_gpio", bus.GPIO_I, 32'h0);
        end
        for (int ph = 0; ph < 4; ph++) begin
            while ((cyc % 4) != ph) @(negedge CLK);
            c = cyc;
            applyStimulus(32'h20, 1'b0, 1'b0);
            expectEvent(32'h20, 32'h0, 32'h20, c + 11, c + 14);
            expectEvent(32'h0, 32'h20, 32'h0, c + 23, c + 26);
            waitCycles(12);
            applyStimulus(32'h0, 1'b0, 1'b0);
            waitCycles(20);
            checkOutput("pulse12_sb_empty", 32'(sb.size()), 32'h0);
            checkOutput("pulse12_gpio", bus.GPIO_I, 32'h0);
        end

        // Chatter with a 6-cycle period never yields three equal samples.
        for (int k = 0; k < 40; k++) begin
            applyStimulus((((k / 3) % 2) == 0) ? 32'h80 : 32'h0, 1'b0, 1'b0);
            waitCycles(1);
        end
        applyStimulus(32'h0, 1'b0, 1'b0);
        waitCycles(20);
        checkOutput("chatter_gpio", bus.GPIO_I, 32'h0);

        // Bypass: 3-cycle pad-to-output, silent exit, then filtered fall.
        applyStimulus(32'h0, 1'b1, 1'b0);
        waitCycles(2);
        c = cyc;
        applyStimulus(32'h8, 1'b1, 1'b0);
        expectEvent(32'h8, 32'h0, 32'h8, c + 3, c + 3);
        waitCycles(6);
        applyStimulus(32'h8, 1'b0, 1'b0);
        waitCycles(12);
        checkOutput("bypass_sb_empty", 32'(sb.size()), 32'h0);
        checkOutput("bypass_gpio", bus.GPIO_I, 32'h8);
        c = cyc;
        applyStimulus(32'h0, 1'b0, 1'b0);
        expectEvent(32'h0, 32'h8, 32'h0, c + 11, c + 14);
        waitCycles(20);
        checkOutput("bypass_fall_sb_empty", 32'(sb.size()), 32'h0);

        // Half the bits rise while the other half fall on the same cycle.
        c = cyc;
        applyStimulus(32'h0000_FFFF, 1'b0, 1'b0);
        expectEvent(32'h0000_FFFF, 32'h0, 32'h0000_FFFF, c + 11, c + 14);
        waitCycles(20);
        c = cyc;
        applyStimulus(32'hFFFF_0000, 1'b0, 1'b0);
        expectEvent(32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_0000, c + 11, c + 14);
        waitCycles(20);
        checkOutput("simul_sb_empty", 32'(sb.size()), 32'h0);
        checkOutput("simul_gpio", bus.GPIO_I, 32'hFFFF_0000);

        // Reset mid-operation clears silently; held pads rise again afterwards.
        applyStimulus(32'hFFFF_0000, 1'b0, 1'b1);
        @(negedge CLK);
        checkOutput("midreset_gpio", bus.GPIO_I, 32'h0);
        checkOutput("midreset_fall", bus.FALL, 32'h0);
        c = cyc;
        applyStimulus(32'hFFFF_0000, 1'b0, 1'b0);
        expectEvent(32'hFFFF_0000, 32'h0, 32'hFFFF_0000, c + 11, c + 14);
        waitCycles(20);
        checkOutput("midreset_sb_empty", 32'(sb.size()), 32'h0);
        checkOutput("midreset_gpio_final", bus.GPIO_I, 32'hFFFF_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
